// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and default widths for the memory arbiter.
package mem_arbiter_pkg;

    // Line address and line data widths (64-bit line granularity)
    localparam int unsigned LINE_ADDR_W = 14;
    localparam int unsigned LINE_DATA_W = 64;

    // Watchdog counter width
    localparam int unsigned WD_W = 4;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MEM  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Grant owner encoding
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter: combinational grant, pointer flips on each advance.
module mem_arbiter_rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_req_icache,
    input  logic i_req_dcache,
    input  logic i_advance,
    output logic o_valid,
    output logic o_owner
);

    logic r_ptr;

    // Grant selection: a lone requester always wins, the pointer only breaks ties
    always_comb begin
        o_valid = i_req_icache | i_req_dcache;
        if (i_req_icache && i_req_dcache) begin
            o_owner = r_ptr;
        end else if (i_req_dcache) begin
            o_owner = OWN_D;
        end else begin
            o_owner = OWN_I;
        end
    end

    // Pointer toggles after every grant, whether or not there was contention
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= OWN_I;
        end else if (i_advance) begin
            r_ptr <= ~r_ptr;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// I-side / D-side line arbiter in front of a single-ported unified memory.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = LINE_ADDR_W,
    parameter int unsigned DATA_W  = LINE_DATA_W,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,
    input  logic              d_re,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_re,
    output logic              m_we,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rd_data,
    input  logic              m_rdy,
    output logic              mem_err
);

    // Last watchdog count value tolerated before the access is abandoned
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_owner;
    logic              r_op_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_i_done;
    logic              r_d_done;
    logic              r_mem_err;
    logic [WD_W-1:0]   r_wd_cnt;

    logic w_d_req;
    logic w_any;
    logic w_owner;
    logic w_grant;
    logic w_complete;
    logic w_timeout;
    logic w_finish;

    assign w_d_req    = d_re | d_we;
    assign w_grant    = (r_state == ST_IDLE) && w_any;
    assign w_complete = (r_state == ST_MEM) && m_rdy;
    assign w_timeout  = (r_state == ST_MEM) && !m_rdy && (r_wd_cnt == WD_LAST);
    assign w_finish   = w_complete || w_timeout;

    mem_arbiter_rr_arb2 u_rr_arb2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req_icache (i_re),
        .i_req_dcache (w_d_req),
        .i_advance    (w_grant),
        .o_valid      (w_any),
        .o_owner      (w_owner)
    );

    // Next-state: IDLE -> MEM on grant, MEM -> RESP on ready or watchdog, RESP -> IDLE
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (w_any)    w_state_nxt = ST_MEM;
            ST_MEM:  if (w_finish) w_state_nxt = ST_RESP;
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latch the winning request; only these copies drive the memory afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner <= OWN_I;
            r_op_wr <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_grant) begin
            r_owner <= w_owner;
            // A D-side write wins over a simultaneous (illegal) D-side read
            r_op_wr <= (w_owner == OWN_D) && d_we;
            r_addr  <= (w_owner == OWN_D) ? d_addr : i_addr;
            r_wdata <= d_wdata;
        end
    end

    // Return path: read data capture on completion, one-cycle done pulse during RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i_rdata <= '0;
            r_d_rdata <= '0;
            r_i_done  <= 1'b0;
            r_d_done  <= 1'b0;
        end else begin
            r_i_done <= w_finish && (r_owner == OWN_I);
            r_d_done <= w_finish && (r_owner == OWN_D);
            if (w_complete && !r_op_wr) begin
                if (r_owner == OWN_I) begin
                    r_i_rdata <= m_rd_data;
                end else begin
                    r_d_rdata <= m_rd_data;
                end
            end
        end
    end

    // Watchdog: cleared on entry to MEM, counts MEM cycles; error flag is sticky
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd_cnt  <= '0;
            r_mem_err <= 1'b0;
        end else begin
            if (w_grant) begin
                r_wd_cnt <= '0;
            end else if (r_state == ST_MEM) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_mem_err <= 1'b1;
            end
        end
    end

    // Strobes decode straight from the state register so they drop the cycle after completion
    assign m_re    = (r_state == ST_MEM) && !r_op_wr;
    assign m_we    = (r_state == ST_MEM) && r_op_wr;
    assign m_addr  = r_addr;
    assign m_wdata = r_wdata;
    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;
    assign i_done  = r_i_done;
    assign d_done  = r_d_done;
    assign mem_err = r_mem_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: 4-clock memory responder plus a transaction-level model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_re = 1'b0;
    logic [13:0] i_addr = '0;
    logic [63:0] i_rdata;
    logic        i_done;
    logic        d_re = 1'b0;
    logic        d_we = 1'b0;
    logic [13:0] d_addr = '0;
    logic [63:0] d_wdata = '0;
    logic [63:0] d_rdata;
    logic        d_done;
    logic [13:0] m_addr;
    logic        m_re;
    logic        m_we;
    logic [63:0] m_wdata;
    logic [63:0] m_rd_data;
    logic        m_rdy;
    logic        mem_err;

    mem_arbiter u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_re      (i_re),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_done    (i_done),
        .d_re      (d_re),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .m_addr    (m_addr),
        .m_re      (m_re),
        .m_we      (m_we),
        .m_wdata   (m_wdata),
        .m_rd_data (m_rd_data),
        .m_rdy     (m_rdy),
        .mem_err   (mem_err)
    );

    always #5 clk = ~clk;

    // Memory responder state (environment side)
    logic [63:0] bus_mem [0:16383];
    bit          mem_inited = 1'b0;
    bit          mem_stall = 1'b0;
    int          mem_cnt = 0;

    // Reference model state (transaction level)
    logic [63:0] ref_mem [0:16383];
    bit          ptr;
    bit          exp_err;
    logic [63:0] exp_i;
    logic [63:0] exp_d;

    int n_pass = 0;
    int n_total = 0;

    function automatic logic [63:0] init_val(input logic [13:0] a);
        return {2'b00, a, 2'b11, ~a, 18'h0, a};
    endfunction

    function automatic logic [13:0] rand_addr();
        if ($urandom_range(0, 1) == 1) return 14'($urandom);
        return 14'($urandom_range(0, 15));
    endfunction

    // Memory: ready in the 4th consecutive cycle of an access, garbage data otherwise
    always @(negedge clk or negedge rst_n) begin
        if (!mem_inited) begin
            for (int a = 0; a < 16384; a++) bus_mem[a] = init_val(14'(a));
            bus_mem[14'h0010] = 64'h1111_2222_3333_4444;
            mem_inited = 1'b1;
        end
        if (!rst_n) begin
            mem_cnt = 0;
            m_rdy   = 1'b0;
        end else if (m_re || m_we) begin
            mem_cnt++;
            if (mem_cnt == 4 && !mem_stall) begin
                m_rdy = 1'b1;
                if (m_re) m_rd_data = bus_mem[m_addr];
                if (m_we) bus_mem[m_addr] = m_wdata;
            end else begin
                m_rdy     = 1'b0;
                m_rd_data = {$urandom, $urandom};
            end
        end else begin
            mem_cnt   = 0;
            m_rdy     = 1'b0;
            m_rd_data = {$urandom, $urandom};
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        ptr     = 1'b0;
        exp_err = 1'b0;
        exp_i   = '0;
        exp_d   = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        i_re  = 1'b0;
        d_re  = 1'b0;
        d_we  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic new_d_req();
        int r;
        r       = $urandom_range(0, 3);
        d_re    = (r != 1);
        d_we    = (r == 1 || r == 3);
        d_addr  = rand_addr();
        d_wdata = {$urandom, $urandom};
    endtask

    // Wait (bounded) for a done pulse; checks strobes, address and data on the way
    task automatic wait_done(input bit own, input bit wr, input logic [13:0] a,
                             input logic [63:0] wd, input int lat, input int mem_start);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 60) begin
            @(negedge clk);
            n++;
            if (i_done || d_done) begin
                seen = 1'b1;
            end else begin
                check("mem_err_hold", 64'(mem_err), 64'(exp_err));
                if (n < mem_start) begin
                    check("strobe_idle", 64'({m_re, m_we}), 64'(0));
                end else begin
                    check("m_re", 64'(m_re), 64'(!wr));
                    check("m_we", 64'(m_we), 64'(wr));
                    check("m_addr", 64'(m_addr), 64'(a));
                    if (wr) check("m_wdata", m_wdata, wd);
                end
            end
        end
        check("done_seen", 64'(seen), 64'(1));
        check("latency", 64'(n), 64'(lat));
        check("done_owner", 64'({d_done, i_done}), own ? 64'(2) : 64'(1));
        check("strobe_resp", 64'({m_re, m_we}), 64'(0));
    endtask

    // Serve ci I-side and cd D-side transactions; each side re-requests while it has work left
    task automatic run_round(input int ci, input int cd, input bit to_mode,
                             input logic [13:0] ia, input logic [13:0] da,
                             input logic [63:0] dw, input bit dre, input bit dwe);
        int          ni;
        int          nd;
        bit          first;
        bit          own;
        bit          wr;
        logic [13:0] a;
        logic [63:0] wd;
        ni    = ci;
        nd    = cd;
        first = 1'b1;
        @(negedge clk);
        if (ni > 0) begin
            i_re   = 1'b1;
            i_addr = ia;
        end
        if (nd > 0) begin
            d_re    = dre;
            d_we    = dwe;
            d_addr  = da;
            d_wdata = dw;
        end
        while (ni > 0 || nd > 0) begin
            own = (ni > 0 && nd > 0) ? ptr : (nd > 0);
            ptr = ~ptr;
            wr  = own && d_we;
            a   = own ? d_addr : i_addr;
            wd  = d_wdata;
            wait_done(own, wr, a, wd, to_mode ? 16 : (first ? 5 : 6), first ? 1 : 2);
            if (to_mode)  exp_err = 1'b1;
            else if (wr)  ref_mem[a] = wd;
            else if (own) exp_d = ref_mem[a];
            else          exp_i = ref_mem[a];
            check("i_rdata", i_rdata, exp_i);
            check("d_rdata", d_rdata, exp_d);
            check("mem_err", 64'(mem_err), 64'(exp_err));
            if (own) begin
                nd--;
                if (nd > 0) new_d_req();
                else begin
                    d_re = 1'b0;
                    d_we = 1'b0;
                end
            end else begin
                ni--;
                if (ni > 0) i_addr = rand_addr();
                else i_re = 1'b0;
            end
            first = 1'b0;
        end
    endtask

    initial begin
        int          ci;
        int          cd;
        int          r;
        logic [13:0] ra;
        logic [13:0] rb;
        logic [63:0] rw;

        for (int a = 0; a < 16384; a++) ref_mem[a] = init_val(14'(a));
        ref_mem[14'h0010] = 64'h1111_2222_3333_4444;
        model_reset();

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_i_done", 64'(i_done), 64'(0));
        check("rst_d_done", 64'(d_done), 64'(0));
        check("rst_m_re", 64'(m_re), 64'(0));
        check("rst_m_we", 64'(m_we), 64'(0));
        check("rst_mem_err", 64'(mem_err), 64'(0));
        check("rst_i_rdata", i_rdata, 64'(0));
        check("rst_d_rdata", d_rdata, 64'(0));
        check("rst_m_addr", 64'(m_addr), 64'(0));
        check("rst_m_wdata", m_wdata, 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // I-read alone
        run_round(1, 0, 1'b0, 14'h0010, 14'h0, 64'h0, 1'b0, 1'b0);
        check("i_read_line", i_rdata, 64'h1111_2222_3333_4444);

        // D-write then D-read of the same line
        run_round(0, 1, 1'b0, 14'h0, 14'h0020, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b1);
        run_round(0, 1, 1'b0, 14'h0, 14'h0020, 64'h0, 1'b1, 1'b0);
        check("d_read_back", d_rdata, 64'hDEAD_BEEF_0123_4567);

        // Contention from reset: I first, then D
        do_reset();
        run_round(1, 1, 1'b0, 14'h0005, 14'h0006, 64'h0, 1'b1, 1'b0);

        // Fairness: both sides requesting for four transactions -> I, D, I, D
        do_reset();
        run_round(2, 2, 1'b0, 14'h0007, 14'h0008, 64'h0, 1'b1, 1'b0);

        // Watchdog timeout on a D read, then the flag survives a normal access
        mem_stall = 1'b1;
        run_round(0, 1, 1'b1, 14'h0, 14'h0009, 64'h0, 1'b1, 1'b0);
        mem_stall = 1'b0;
        run_round(1, 1, 1'b0, 14'h000A, 14'h000B, 64'h0, 1'b1, 1'b0);

        // Reset in the middle of a read
        @(negedge clk);
        i_re   = 1'b1;
        i_addr = 14'h0030;
        repeat (2) @(negedge clk);
        check("mid_m_re_before", 64'(m_re), 64'(1));
        rst_n = 1'b0;
        i_re  = 1'b0;
        #1;
        check("mid_m_re", 64'(m_re), 64'(0));
        check("mid_m_addr", 64'(m_addr), 64'(0));
        check("mid_mem_err", 64'(mem_err), 64'(0));
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("mid_no_done", 64'({i_done, d_done}), 64'(0));
        end
        rst_n = 1'b1;
        model_reset();
        run_round(1, 0, 1'b0, 14'h0030, 14'h0, 64'h0, 1'b0, 1'b0);

        // Randomised rounds
        for (int t = 0; t < 30; t++) begin
            ci = $urandom_range(0, 2);
            cd = $urandom_range(0, 2);
            if (ci + cd == 0) ci = 1;
            r  = $urandom_range(0, 3);
            ra = rand_addr();
            rb = rand_addr();
            rw = {$urandom, $urandom};
            run_round(ci, cd, 1'b0, ra, rb, rw, r != 1, r == 1 || r == 3);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
